// File: rtl/circle_drawer.sv
// Midpoint circle rasteriser driving a 160x120 VGA pixel-write port, one pixel per clock.
// Optional macro CIRCLE_CLIP_EN suppresses vga_plot for pixels outside the screen.
module circle_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DRAW     = 2'b01,
    UPDATE   = 2'b10,
    END_DRAW = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [2:0]         r_octant;
  logic [8:0]         r_offset_x;
  logic [8:0]         r_offset_y;
  logic signed [10:0] r_crit;
  logic [7:0]         r_cx;
  logic [6:0]         r_cy;
  logic [2:0]         r_colour;
  logic [7:0]         r_hold_x;
  logic [6:0]         r_hold_y;

  logic signed [10:0] w_cx;
  logic signed [10:0] w_cy;
  logic signed [10:0] w_ox;
  logic signed [10:0] w_oy;
  logic signed [10:0] w_px;
  logic signed [10:0] w_py;
  logic signed [10:0] w_ox_new;
  logic signed [10:0] w_oy_new;
  logic signed [10:0] w_crit_new;
  logic               w_on_screen;

  // Offsets are treated as signed so offset_x may step below zero (radius 0) and still compare correctly.
  assign w_cx = $signed({3'b000, r_cx});
  assign w_cy = $signed({4'b0000, r_cy});
  assign w_ox = $signed({{2{r_offset_x[8]}}, r_offset_x});
  assign w_oy = $signed({{2{r_offset_y[8]}}, r_offset_y});

  assign w_oy_new   = w_oy + 11'sd1;
  assign w_ox_new   = (r_crit <= 11'sd0) ? w_ox : (w_ox - 11'sd1);
  assign w_crit_new = (r_crit <= 11'sd0) ? (r_crit + (w_oy_new <<< 1) + 11'sd1)
                                         : (r_crit + ((w_oy_new - w_ox_new) <<< 1) + 11'sd1);

  assign w_on_screen = (w_px >= 11'sd0) && (w_px < $signed(11'(SCREEN_W))) &&
                       (w_py >= 11'sd0) && (w_py < $signed(11'(SCREEN_H)));

  // Octant-to-coordinate mapping for the current pixel
  always_comb begin
    w_px = w_cx;
    w_py = w_cy;
    case (r_octant)
      3'd0: begin w_px = w_cx + w_ox; w_py = w_cy + w_oy; end
      3'd1: begin w_px = w_cx + w_oy; w_py = w_cy + w_ox; end
      3'd2: begin w_px = w_cx - w_ox; w_py = w_cy + w_oy; end
      3'd3: begin w_px = w_cx - w_oy; w_py = w_cy + w_ox; end
      3'd4: begin w_px = w_cx - w_ox; w_py = w_cy - w_oy; end
      3'd5: begin w_px = w_cx - w_oy; w_py = w_cy - w_ox; end
      3'd6: begin w_px = w_cx + w_ox; w_py = w_cy - w_oy; end
      3'd7: begin w_px = w_cx + w_oy; w_py = w_cy - w_ox; end
      default: begin w_px = w_cx; w_py = w_cy; end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and pixel-port outputs
  always_comb begin
    w_next_state = r_state;
    done         = 1'b0;
    vga_x        = 8'd0;
    vga_y        = 7'd0;
    vga_colour   = 3'd0;
    vga_plot     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = DRAW;
        end else begin
          w_next_state = IDLE;
        end
      end
      DRAW: begin
        vga_x      = w_px[7:0];
        vga_y      = w_py[6:0];
        vga_colour = r_colour;
`ifdef CIRCLE_CLIP_EN
        vga_plot   = w_on_screen;
`else
        vga_plot   = 1'b1;
`endif
        if (r_octant == 3'd7) begin
          w_next_state = UPDATE;
        end else begin
          w_next_state = DRAW;
        end
      end
      UPDATE: begin
        vga_x      = r_hold_x;
        vga_y      = r_hold_y;
        vga_colour = r_colour;
        if (w_oy_new <= w_ox_new) begin
          w_next_state = DRAW;
        end else begin
          w_next_state = END_DRAW;
        end
      end
      END_DRAW: begin
        done  = 1'b1;
        vga_x = r_hold_x;
        vga_y = r_hold_y;
        if (start) begin
          w_next_state = END_DRAW;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Latched parameters, octant walk and midpoint error term
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_octant   <= 3'd0;
      r_offset_x <= 9'd0;
      r_offset_y <= 9'd0;
      r_crit     <= 11'sd0;
      r_cx       <= 8'd0;
      r_cy       <= 7'd0;
      r_colour   <= 3'd0;
      r_hold_x   <= 8'd0;
      r_hold_y   <= 7'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cx       <= centre_x;
            r_cy       <= centre_y;
            r_colour   <= colour;
            r_offset_x <= {1'b0, radius};
            r_offset_y <= 9'd0;
            r_crit     <= 11'sd1 - $signed({3'b000, radius});
            r_octant   <= 3'd0;
          end
        end
        DRAW: begin
          r_octant <= r_octant + 3'd1;
          r_hold_x <= w_px[7:0];
          r_hold_y <= w_py[6:0];
        end
        UPDATE: begin
          r_offset_y <= w_oy_new[8:0];
          r_offset_x <= w_ox_new[8:0];
          r_crit     <= w_crit_new;
        end
        default: begin
          r_octant <= r_octant;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circle_drawer.sv
// Self-checking bench for circle_drawer: a reference midpoint model fills a scoreboard that is drained cycle by cycle.
module tb_circle_drawer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic       start;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       plot;
    logic       dn;
    logic       chk_xy;
    logic       chk_col;
  } exp_t;

  exp_t sb[$];

  circle_drawer dut (
    .clk(clk), .rst(rst), .colour(colour), .centre_x(centre_x), .centre_y(centre_y),
    .radius(radius), .start(start), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  function automatic void model(input int cx, input int cy, input int r, input logic [2:0] col);
    int ox = r;
    int oy = 0;
    int crit = 1 - r;
    int px, py;
    exp_t e;
    do begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - ox; py = cy + oy; end
          3: begin px = cx - oy; py = cy + ox; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + ox; py = cy - oy; end
          default: begin px = cx + oy; py = cy - ox; end
        endcase
        e.x = 8'(px); e.y = 7'(py); e.col = col; e.dn = 1'b0; e.chk_xy = 1'b1; e.chk_col = 1'b1;
`ifdef CIRCLE_CLIP_EN
        e.plot = (px >= 0 && px < 160 && py >= 0 && py < 120);
`else
        e.plot = 1'b1;
`endif
        sb.push_back(e);
      end
      // UPDATE cycle holds the octant-7 coordinates
      e.plot = 1'b0; e.dn = 1'b0;
      sb.push_back(e);
      oy = oy + 1;
      if (crit <= 0) begin
        crit = crit + 2 * oy + 1;
      end else begin
        ox = ox - 1;
        crit = crit + 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
    e.plot = 1'b0; e.dn = 1'b1; e.chk_xy = 1'b0; e.chk_col = 1'b0;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'b010;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (vga_x !== 8'd0)      begin n_errors++; $display("FAIL reset vga_x got %0d exp 0", vga_x); end
    if (vga_y !== 7'd0)      begin n_errors++; $display("FAIL reset vga_y got %0d exp 0", vga_y); end
    if (vga_colour !== 3'd0) begin n_errors++; $display("FAIL reset vga_colour got %0d exp 0", vga_colour); end
    if (vga_plot !== 1'b0)   begin n_errors++; $display("FAIL reset vga_plot got %0b exp 0", vga_plot); end
    if (done !== 1'b0)       begin n_errors++; $display("FAIL reset done got %0b exp 0", done); end
  endtask

  task automatic test_first_iter();
    int tx[8] = '{120, 80, 40, 80, 40, 80, 120, 80};
    int ty[8] = '{60, 100, 60, 100, 60, 20, 60, 20};
    int budget;
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'b010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks += 4;
      if (vga_x !== 8'(tx[i]))   begin n_errors++; $display("FAIL first_iter[%0d] x got %0d exp %0d", i, vga_x, tx[i]); end
      if (vga_y !== 7'(ty[i]))   begin n_errors++; $display("FAIL first_iter[%0d] y got %0d exp %0d", i, vga_y, ty[i]); end
      if (vga_plot !== 1'b1)     begin n_errors++; $display("FAIL first_iter[%0d] plot got %0b exp 1", i, vga_plot); end
      if (vga_colour !== 3'b010) begin n_errors++; $display("FAIL first_iter[%0d] colour got %0d exp 2", i, vga_colour); end
      @(negedge clk);
    end
    n_checks += 2;
    if (vga_plot !== 1'b0) begin n_errors++; $display("FAIL first_iter update plot got %0b exp 0", vga_plot); end
    if (done !== 1'b0)     begin n_errors++; $display("FAIL first_iter update done got %0b exp 0", done); end
    budget = 0;
    while (done !== 1'b1 && budget < 2000) begin @(negedge clk); budget++; end
    n_checks++;
    if (done !== 1'b1) begin n_errors++; $display("FAIL first_iter timeout done got %0b exp 1", done); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL first_iter idle done got %0b exp 0", done); end
  endtask

  task automatic run_circle(input logic [7:0] cx, input logic [6:0] cy, input logic [7:0] r,
                            input logic [2:0] col, input bit hold, input string name);
    exp_t e;
    int idx = 0;
    model(int'(cx), int'(cy), int'(r), col);
    centre_x = cx; centre_y = cy; radius = r; colour = col;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom); colour = 3'($urandom);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks += 2;
      if (vga_plot !== e.plot) begin n_errors++; $display("FAIL %s[%0d] plot got %0b exp %0b", name, idx, vga_plot, e.plot); end
      if (done !== e.dn)       begin n_errors++; $display("FAIL %s[%0d] done got %0b exp %0b", name, idx, done, e.dn); end
      if (e.chk_xy) begin
        n_checks += 2;
        if (vga_x !== e.x) begin n_errors++; $display("FAIL %s[%0d] x got %0d exp %0d", name, idx, vga_x, e.x); end
        if (vga_y !== e.y) begin n_errors++; $display("FAIL %s[%0d] y got %0d exp %0d", name, idx, vga_y, e.y); end
      end
      if (e.chk_col) begin
        n_checks++;
        if (vga_colour !== e.col) begin n_errors++; $display("FAIL %s[%0d] colour got %0d exp %0d", name, idx, vga_colour, e.col); end
      end
      idx++;
      @(negedge clk);
    end
    if (hold) begin
      n_checks++;
      if (done !== 1'b1) begin n_errors++; $display("FAIL %s hold done got %0b exp 1", name, done); end
      start = 1'b0;
      @(negedge clk);
    end
    n_checks += 3;
    if (done !== 1'b0)     begin n_errors++; $display("FAIL %s idle done got %0b exp 0", name, done); end
    if (vga_plot !== 1'b0) begin n_errors++; $display("FAIL %s idle plot got %0b exp 0", name, vga_plot); end
    if (vga_x !== 8'd0)    begin n_errors++; $display("FAIL %s idle x got %0d exp 0", name, vga_x); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      run_circle(8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 8'($urandom_range(0, 30)),
                 3'($urandom), bit'(k % 2), "random");
    end
  endtask

  task automatic test_reset_mid_draw();
    centre_x = 8'd50; centre_y = 7'd50; radius = 8'd20; colour = 3'b111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks += 5;
    if (vga_x !== 8'd0)      begin n_errors++; $display("FAIL midrst x got %0d exp 0", vga_x); end
    if (vga_y !== 7'd0)      begin n_errors++; $display("FAIL midrst y got %0d exp 0", vga_y); end
    if (vga_colour !== 3'd0) begin n_errors++; $display("FAIL midrst colour got %0d exp 0", vga_colour); end
    if (vga_plot !== 1'b0)   begin n_errors++; $display("FAIL midrst plot got %0b exp 0", vga_plot); end
    if (done !== 1'b0)       begin n_errors++; $display("FAIL midrst done got %0b exp 0", done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vga_plot !== 1'b0) begin n_errors++; $display("FAIL midrst stays idle plot got %0b exp 0", vga_plot); end
  endtask

  initial begin
    test_reset();
    test_first_iter();
    run_circle(8'd80, 7'd60, 8'd40, 3'b010, 1'b1, "r40");
    run_circle(8'd10, 7'd10, 8'd0, 3'b101, 1'b0, "r0");
    run_circle(8'd5, 7'd5, 8'd10, 3'b011, 1'b0, "edge");
    run_circle(8'd155, 7'd115, 8'd12, 3'b110, 1'b0, "corner");
    test_back_to_back();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
